// File: rtl/trng_mmio_pkg.sv
// Shared definitions for the TRNG MMIO FIFO: register offsets, field positions and bus FSM states.
package trng_mmio_pkg;

   localparam logic [3:0] OFF_DATA   = 4'h0;
   localparam logic [3:0] OFF_STATUS = 4'h4;
   localparam logic [3:0] OFF_CTRL   = 4'h8;

   localparam int unsigned ST_EMPTY     = 0;
   localparam int unsigned ST_FULL      = 1;
   localparam int unsigned ST_OVERFLOW  = 2;
   localparam int unsigned ST_UNDERFLOW = 3;
   localparam int unsigned ST_REP_FAIL  = 4;
   localparam int unsigned ST_COUNT_LSB = 8;

   localparam int unsigned CTRL_ENABLE = 0;
   localparam int unsigned CTRL_CLEAR  = 1;

   typedef enum logic {
      IDLE,
      ACK
   } bus_state_e;

   function automatic logic [31:0] pack_status(input logic       empty,
                                               input logic       full,
                                               input logic       overflow,
                                               input logic       underflow,
                                               input logic       rep_fail,
                                               input logic [7:0] count);
      logic [31:0] s;
      s                             = '0;
      s[ST_EMPTY]                   = empty;
      s[ST_FULL]                    = full;
      s[ST_OVERFLOW]                = overflow;
      s[ST_UNDERFLOW]               = underflow;
      s[ST_REP_FAIL]                = rep_fail;
      s[ST_COUNT_LSB +: 8]          = count;
      return s;
   endfunction

endpackage

// File: rtl/trng_word_fifo.sv
// Synchronous first-word-fall-through FIFO; push is accepted when full only alongside a pop.
module trng_word_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AddrW = $clog2(DEPTH);
   localparam int unsigned CntW  = AddrW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AddrW-1:0] wptr_q, wptr_d;
   logic [AddrW-1:0] rptr_q, rptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CntW'(DEPTH));
   assign count   = count_q;
   assign dout    = mem_q[rptr_q];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (clear) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (do_push) wptr_d = wptr_q + 1'b1;
         if (do_pop)  rptr_d = rptr_q + 1'b1;
         if (do_push && !do_pop)      count_d = count_q + 1'b1;
         else if (do_pop && !do_push) count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Storage carries no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push && !clear) mem_q[wptr_q] <= din;
   end

endmodule

// File: rtl/trng_mmio_fifo.sv
// Repetition-count screened TRNG word buffer exposed as a PicoRV32 native-bus slave.
module trng_mmio_fifo
   import trng_mmio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned REP_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] rng_data,
   input  logic        rng_valid,
   input  logic        mem_valid,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic        mem_ready,
   output logic [31:0] mem_rdata,
   output logic        rng_irq
);

   localparam int unsigned CntW   = $clog2(DEPTH) + 1;
   localparam int unsigned RepW   = $clog2(REP_LIMIT) + 1;
   localparam logic [RepW-1:0] RepMax = RepW'(REP_LIMIT - 1);

   bus_state_e      state_q, state_d;
   logic [31:0]     rdata_q, rdata_d;
   logic            enable_q, enable_d;
   logic            ovf_q, ovf_d;
   logic            udf_q, udf_d;
   logic            rep_fail_q, rep_fail_d;
   logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
   logic [31:0]     prev_word_q, prev_word_d;
   logic            prev_ok_q, prev_ok_d;

   logic            sel, accept, is_write, ctrl_wr, data_rd;
   logic [3:0]      off;
   logic            rng_take, rep_hit, want_push;
   logic            fifo_push, fifo_pop, fifo_clear, fifo_empty, fifo_full;
   logic [31:0]     fifo_dout;
   logic [CntW-1:0] fifo_count;
   logic [31:0]     status_word, ctrl_word;
   logic            unused_bits;

   assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:2]};

   // Offset 0xC inside the 16-byte window is left for another slave.
   assign sel      = (mem_addr[31:4] == BASE_ADDR[31:4]) && (mem_addr[3:2] != 2'b11);
   assign off      = {mem_addr[3:2], 2'b00};
   assign is_write = |mem_wstrb;
   assign accept   = (state_q == IDLE) && mem_valid && sel;
   assign ctrl_wr  = accept && is_write && (off == OFF_CTRL) && mem_wstrb[0];
   assign data_rd  = accept && !is_write && (off == OFF_DATA);

   assign fifo_clear = ctrl_wr && mem_wdata[CTRL_CLEAR];
   assign fifo_pop   = data_rd && !fifo_empty;
   assign rng_take   = rng_valid && enable_q && !fifo_clear;
   assign fifo_push  = want_push && (!fifo_full || fifo_pop);

   trng_word_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clear (fifo_clear),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (rng_data),
      .dout  (fifo_dout),
      .empty (fifo_empty),
      .full  (fifo_full),
      .count (fifo_count)
   );

   // Repetition-count health test; a tripped word is dropped and the counter saturates.
   always_comb begin
      rep_cnt_d   = rep_cnt_q;
      prev_word_d = prev_word_q;
      prev_ok_d   = prev_ok_q;
      rep_hit     = 1'b0;
      want_push   = 1'b0;
      if (fifo_clear) begin
         rep_cnt_d = '0;
      end else if (rng_take) begin
         if (prev_ok_q && (rng_data == prev_word_q)) begin
            rep_cnt_d = (rep_cnt_q == RepMax) ? rep_cnt_q : rep_cnt_q + 1'b1;
         end else begin
            rep_cnt_d = '0;
         end
         prev_word_d = rng_data;
         prev_ok_d   = 1'b1;
         rep_hit     = (rep_cnt_d == RepMax);
         want_push   = !rep_hit;
      end
   end

   always_comb begin
      enable_d   = enable_q;
      ovf_d      = ovf_q;
      udf_d      = udf_q;
      rep_fail_d = rep_fail_q;
      if (ctrl_wr) enable_d = mem_wdata[CTRL_ENABLE];
      if (fifo_clear) begin
         ovf_d      = 1'b0;
         udf_d      = 1'b0;
         rep_fail_d = 1'b0;
      end else begin
         if (want_push && fifo_full && !fifo_pop) ovf_d = 1'b1;
         if (rep_hit)                             rep_fail_d = 1'b1;
         if (data_rd && fifo_empty)               udf_d = 1'b1;
      end
   end

   assign status_word = pack_status(fifo_empty, fifo_full, ovf_q, udf_q, rep_fail_q,
                                    8'(fifo_count));
   assign ctrl_word   = {31'b0, enable_q};

   // Read data is captured at accept and held for the single ACK cycle, zero otherwise.
   always_comb begin
      rdata_d = '0;
      if (accept && !is_write) begin
         case (off)
            OFF_DATA:   rdata_d = fifo_empty ? 32'h0 : fifo_dout;
            OFF_STATUS: rdata_d = status_word;
            OFF_CTRL:   rdata_d = ctrl_word;
            default:    rdata_d = '0;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (accept) state_d = ACK;
         ACK:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rdata_q     <= '0;
         enable_q    <= 1'b1;
         ovf_q       <= 1'b0;
         udf_q       <= 1'b0;
         rep_fail_q  <= 1'b0;
         rep_cnt_q   <= '0;
         prev_word_q <= '0;
         prev_ok_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rdata_q     <= rdata_d;
         enable_q    <= enable_d;
         ovf_q       <= ovf_d;
         udf_q       <= udf_d;
         rep_fail_q  <= rep_fail_d;
         rep_cnt_q   <= rep_cnt_d;
         prev_word_q <= prev_word_d;
         prev_ok_q   <= prev_ok_d;
      end
   end

   assign mem_ready = (state_q == ACK);
   assign mem_rdata = rdata_q;
   assign rng_irq   = !fifo_empty && enable_q;

endmodule

// File: tb/tb_trng_mmio_fifo.sv
// Directed bench for trng_mmio_fifo: vector table plus hand-written multi-cycle corner cases.
module tb_trng_mmio_fifo;

   localparam logic [31:0] BASE = 32'h0200_0000;
   localparam logic [3:0]  D    = 4'h0;
   localparam logic [3:0]  S    = 4'h4;
   localparam logic [3:0]  C    = 4'h8;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] rng_data;
   logic        rng_valid;
   logic        mem_valid;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        rng_irq;

   int n_tests = 0;
   int n_fail  = 0;

   trng_mmio_fifo #(
      .BASE_ADDR (BASE),
      .DEPTH     (8),
      .REP_LIMIT (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rng_data  (rng_data),
      .rng_valid (rng_valid),
      .mem_valid (mem_valid),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wstrb (mem_wstrb),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata),
      .rng_irq   (rng_irq)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   typedef enum int {V_PUSH, V_RD, V_WR, V_IRQ} kind_e;

   typedef struct {
      kind_e       kind;
      logic [3:0]  off;
      logic [3:0]  strb;
      logic [31:0] data;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[$];

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endfunction

   function automatic void add(input kind_e k, input logic [3:0] off, input logic [3:0] strb,
                               input logic [31:0] d, input logic [31:0] e, input string n);
      vec_t v;
      v.kind = k;
      v.off  = off;
      v.strb = strb;
      v.data = d;
      v.exp  = e;
      v.name = n;
      vecs.push_back(v);
   endfunction

   function automatic void v_push(input logic [31:0] d);
      add(V_PUSH, 4'h0, 4'h0, d, 32'h0, "push");
   endfunction

   function automatic void v_rd(input logic [3:0] off, input logic [31:0] e, input string n);
      add(V_RD, off, 4'h0, 32'h0, e, n);
   endfunction

   function automatic void v_wr(input logic [3:0] off, input logic [3:0] strb,
                                input logic [31:0] d);
      add(V_WR, off, strb, d, 32'h0, "write");
   endfunction

   function automatic void v_irq(input logic e, input string n);
      add(V_IRQ, 4'h0, 4'h0, 32'h0, {31'b0, e}, n);
   endfunction

   task automatic push_word(input logic [31:0] d);
      @(negedge clk);
      rng_valid = 1'b1;
      rng_data  = d;
      @(negedge clk);
      rng_valid = 1'b0;
   endtask

   // One bus access; optionally strobes rng_valid on the same edge the request is sampled.
   task automatic bus_access(input logic [31:0] addr, input logic [3:0] strb,
                             input logic [31:0] wd, input logic with_rng,
                             input logic [31:0] rngd, output logic [31:0] rd,
                             output int lat);
      @(negedge clk);
      mem_valid = 1'b1;
      mem_addr  = addr;
      mem_wstrb = strb;
      mem_wdata = wd;
      if (with_rng) begin
         rng_valid = 1'b1;
         rng_data  = rngd;
      end
      lat = -1;
      rd  = 32'h0;
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk);
         #1;
         rng_valid = 1'b0;
         if (mem_ready) begin
            lat = i;
            rd  = mem_rdata;
            break;
         end
      end
      @(posedge clk);
      #1;
      check("ready_one_cycle", {31'b0, mem_ready}, 32'h0);
      check("rdata_idle_zero", mem_rdata, 32'h0);
      mem_valid = 1'b0;
      mem_wstrb = 4'h0;
   endtask

   logic [31:0] rd;
   int          lat;

   initial begin
      rst       = 1'b1;
      rng_data  = 32'h0;
      rng_valid = 1'b0;
      mem_valid = 1'b0;
      mem_addr  = 32'h0;
      mem_wdata = 32'h0;
      mem_wstrb = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_ready", {31'b0, mem_ready}, 32'h0);
      check("reset_rdata", mem_rdata, 32'h0);
      check("reset_irq", {31'b0, rng_irq}, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Reset state and in-order readout
      v_rd(S, 32'h0000_0001, "status_reset");
      v_irq(1'b0, "irq_reset");
      v_push(32'hA1); v_push(32'hB2); v_push(32'hC3);
      v_irq(1'b1, "irq_nonempty");
      v_rd(S, 32'h0000_0300, "status_3");
      v_rd(D, 32'hA1, "data_a1");
      v_rd(D, 32'hB2, "data_b2");
      v_rd(D, 32'hC3, "data_c3");
      v_rd(S, 32'h0000_0001, "status_drained");
      v_irq(1'b0, "irq_drained");
      // Overflow then clear (0x2 also drops enable)
      for (int i = 0; i < 9; i++) v_push(32'h100 + 32'(i));
      v_rd(S, 32'h0000_0806, "status_overflow");
      v_wr(C, 4'hF, 32'h2);
      v_rd(S, 32'h0000_0001, "status_cleared");
      v_rd(C, 32'h0, "ctrl_disabled");
      v_wr(C, 4'hF, 32'h1);
      v_rd(C, 32'h1, "ctrl_enabled");
      // Repetition-count test
      for (int i = 0; i < 5; i++) v_push(32'hDEADBEEF);
      v_rd(S, 32'h0000_0310, "status_rep_fail");
      v_push(32'h1234_5678);
      v_rd(S, 32'h0000_0410, "status_rep_recover");
      v_rd(D, 32'hDEADBEEF, "data_rep0");
      v_rd(D, 32'hDEADBEEF, "data_rep1");
      v_rd(D, 32'hDEADBEEF, "data_rep2");
      v_rd(D, 32'h1234_5678, "data_after_rep");
      // Underflow and enable gating
      v_rd(D, 32'h0, "data_underflow");
      v_rd(S, 32'h0000_0019, "status_underflow");
      v_wr(C, 4'hF, 32'h0);
      v_push(32'h55);
      v_rd(S, 32'h0000_0019, "status_disabled_push");
      v_wr(C, 4'hF, 32'h3);
      v_rd(S, 32'h0000_0001, "status_clear2");
      v_push(32'h77);
      v_irq(1'b1, "irq_one");
      v_rd(S, 32'h0000_0100, "status_one");
      v_wr(C, 4'h2, 32'h0);
      v_rd(C, 32'h1, "ctrl_strb0_ignored");
      v_wr(C, 4'hF, 32'h0);
      v_irq(1'b0, "irq_masked");
      v_rd(C, 32'h0, "ctrl_off");
      v_push(32'h88);
      v_rd(S, 32'h0000_0100, "status_disabled2");
      v_wr(D, 4'hF, 32'hFFFF_FFFF);
      v_rd(S, 32'h0000_0100, "status_wr_data_ignored");
      v_wr(S, 4'hF, 32'hFFFF_FFFF);
      v_rd(S, 32'h0000_0100, "status_wr_status_ignored");
      v_wr(C, 4'hF, 32'h1);
      v_irq(1'b1, "irq_unmasked");
      v_rd(D, 32'h77, "data_77");
      v_rd(S, 32'h0000_0001, "status_final");

      foreach (vecs[i]) begin
         case (vecs[i].kind)
            V_PUSH: push_word(vecs[i].data);
            V_RD: begin
               bus_access(BASE + {28'b0, vecs[i].off}, 4'h0, 32'h0, 1'b0, 32'h0, rd, lat);
               check({vecs[i].name, "_lat"}, 32'(lat), 32'd1);
               check(vecs[i].name, rd, vecs[i].exp);
            end
            V_WR: begin
               bus_access(BASE + {28'b0, vecs[i].off}, vecs[i].strb, vecs[i].data, 1'b0,
                          32'h0, rd, lat);
               check("write_lat", 32'(lat), 32'd1);
            end
            V_IRQ: begin
               @(negedge clk);
               check(vecs[i].name, {31'b0, rng_irq}, vecs[i].exp);
            end
            default: ;
         endcase
      end

      // Full FIFO: push coincident with pop keeps count, no overflow
      bus_access(BASE + 32'h8, 4'hF, 32'h3, 1'b0, 32'h0, rd, lat);
      for (int i = 0; i < 8; i++) push_word(32'h200 + 32'(i));
      bus_access(BASE, 4'h0, 32'h0, 1'b1, 32'h300, rd, lat);
      check("full_pushpop_data", rd, 32'h200);
      check("full_pushpop_lat", 32'(lat), 32'd1);
      bus_access(BASE + 32'h4, 4'h0, 32'h0, 1'b0, 32'h0, rd, lat);
      check("full_pushpop_status", rd, 32'h0000_0802);
      for (int i = 0; i < 8; i++) begin
         bus_access(BASE, 4'h0, 32'h0, 1'b0, 32'h0, rd, lat);
         check("full_drain", rd, (i < 7) ? 32'h201 + 32'(i) : 32'h300);
      end

      // Empty FIFO: coincident pop sees empty, push still lands
      bus_access(BASE, 4'h0, 32'h0, 1'b1, 32'h400, rd, lat);
      check("empty_pushpop_data", rd, 32'h0);
      bus_access(BASE + 32'h4, 4'h0, 32'h0, 1'b0, 32'h0, rd, lat);
      check("empty_pushpop_status", rd, 32'h0000_0108);
      bus_access(BASE, 4'h0, 32'h0, 1'b0, 32'h0, rd, lat);
      check("empty_pushpop_word", rd, 32'h400);

      // Clear coincident with rng_valid discards the word
      push_word(32'h500);
      bus_access(BASE + 32'h8, 4'hF, 32'h3, 1'b1, 32'h600, rd, lat);
      bus_access(BASE + 32'h4, 4'h0, 32'h0, 1'b0, 32'h0, rd, lat);
      check("clear_wins_status", rd, 32'h0000_0001);

      // Unmapped addresses never acknowledge
      bus_access(BASE + 32'hC, 4'h0, 32'h0, 1'b0, 32'h0, rd, lat);
      check("unmapped_0xc", 32'(lat), 32'hFFFF_FFFF);
      bus_access(BASE + 32'h10, 4'h0, 32'h0, 1'b0, 32'h0, rd, lat);
      check("unmapped_0x10", 32'(lat), 32'hFFFF_FFFF);

      // Reset dominates a pending request and restores enable
      bus_access(BASE + 32'h8, 4'hF, 32'h0, 1'b0, 32'h0, rd, lat);
      push_word(32'h700);
      @(negedge clk);
      mem_valid = 1'b1;
      mem_addr  = BASE + 32'h4;
      mem_wstrb = 4'h0;
      rst       = 1'b1;
      @(posedge clk);
      #1;
      check("reset_mid_ready", {31'b0, mem_ready}, 32'h0);
      @(posedge clk);
      #1;
      check("reset_mid_ready2", {31'b0, mem_ready}, 32'h0);
      @(negedge clk);
      mem_valid = 1'b0;
      rst       = 1'b0;
      bus_access(BASE + 32'h8, 4'h0, 32'h0, 1'b0, 32'h0, rd, lat);
      check("reset_ctrl", rd, 32'h1);
      bus_access(BASE + 32'h4, 4'h0, 32'h0, 1'b0, 32'h0, rd, lat);
      check("reset_status", rd, 32'h0000_0001);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/trng_mmio_fifo.md
Name: trng_mmio_fifo

Overview:
- Sits directly downstream of the TRNG word assembler and consumes its 32-bit random word stream (data + one-cycle valid strobe).
- Screens each word with a repetition-count health test, then buffers accepted words in a small FIFO.
- Exposes the FIFO, status and control to the PicoRV32 core as a memory-mapped slave on the native memory interface.

Parameters:
- BASE_ADDR, 32'h0200_0000: byte address of the register window. The window holds 3 words, at offsets 0x0, 0x4 and 0x8.
- DEPTH, 8: FIFO depth in words. Must be a power of 2, range 2..128.
- REP_LIMIT, 4: number of identical consecutive input words that trips the health test. Must be at least 2.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- rng_data  in  32  random word from the TRNG assembler
- rng_valid  in  1  one-cycle strobe; rng_data is valid on this cycle
- mem_valid  in  1  PicoRV32 bus request
- mem_addr  in  32  byte address
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte strobes; 0 means read
- mem_ready  out  1  one-cycle acknowledge
- mem_rdata  out  32  read data, valid while mem_ready=1
- rng_irq  out  1  level, high when the FIFO is not empty and enable=1

Behaviour:
- Single clock domain. Reset is synchronous, active-high, named rst, sampled on the rising edge of clk.
- Reset values:
  - Outputs: mem_ready=0, mem_rdata=0, rng_irq=0.
  - FIFO: empty, count=0, pointers=0.
  - Sticky flags cleared; rep_cnt=0; prev_word=0; prev_ok=0.
  - enable=1.
- Register map (offset from BASE_ADDR):
  - 0x0 DATA, read-only. A read pops one FIFO word. A read while empty returns 0, does not pop, and sets sticky underflow.
  - 0x4 STATUS, read-only:
    - [0] empty
    - [1] full
    - [2] overflow (sticky)
    - [3] underflow (sticky)
    - [4] rep_fail (sticky)
    - [15:8] count
    - all other bits 0
  - 0x8 CTRL:
    - [0] enable, read/write.
    - [1] clear, write-only, self-clearing, reads as 0. Writing 1 flushes the FIFO, clears all sticky flags and sets rep_cnt=0.
    - A write takes effect only when mem_wstrb[0]=1.
  - Writes to DATA or STATUS are acknowledged and ignored.
- Address decode: the slave is selected when mem_addr[31:4] == BASE_ADDR[31:4] and mem_addr[3:2] != 2'b11.
  - Unselected addresses: mem_ready stays 0, so another slave can respond.
- Bus FSM, two states:
  - IDLE: when mem_valid && selected, perform the access (pop, register write) and go to ACK.
  - ACK: mem_ready=1 and mem_rdata driven for exactly one cycle, then return to IDLE.
  - Latency: mem_ready is asserted 1 cycle after mem_valid is first sampled. The FSM never re-accepts in the ACK cycle.
  - mem_rdata returns to 0 whenever mem_ready=0.
- Input path, evaluated on each rng_valid:
  - enable=0: the word is discarded, with no health update.
  - Health test: if prev_ok && rng_data == prev_word, then rep_cnt++; otherwise rep_cnt=0. Then prev_word=rng_data and prev_ok=1.
  - If rep_cnt reaches REP_LIMIT-1: set rep_fail, drop the word, saturate rep_cnt.
  - Otherwise push. If the FIFO is full with no simultaneous pop: drop the word and set overflow.
- Simultaneous push and pop:
  - FIFO full: allowed, count unchanged.
  - FIFO empty: the pop sees empty, so it returns 0 and sets underflow. The push still lands.
- Clear coincident with rng_valid: clear wins and the word is discarded.
- rep_fail does not block later pushes; software polls it.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately and mem_ready=0 on the next cycle.
- count width is $clog2(DEPTH)+1, zero-extended into STATUS[15:8].

Decomposition:
- Package trng_mmio_pkg holds:
  - register offsets: OFF_DATA=0x0, OFF_STATUS=0x4, OFF_CTRL=0x8
  - STATUS bit indices
  - CTRL bit indices
  - bus FSM state enum {IDLE, ACK}
- Sub-module trng_word_fifo, a synchronous FIFO:
  - Parameters: DEPTH, width 32.
  - Signals: push, pop, din, dout, empty, full, count.
  - First-word fall-through: dout is valid whenever empty=0.
- Health test, address decode and the bus FSM stay in the top module.

Test Plan:
- Reset, then read STATUS → rdata=32'h0000_0001 (empty=1, count=0); rng_irq=0.
- Push 3 words A1,B2,C3, then read DATA 3 times → returns A1, B2, C3 in order. mem_ready rises exactly 1 cycle after mem_valid each time. Final STATUS empty=1.
- Push 9 distinct words into DEPTH=8 → the 9th is dropped; STATUS = full=1, overflow=1, count=8. Write CTRL=0x2 → STATUS=0x1.
- Send 5 identical words 0xDEADBEEF with REP_LIMIT=4 → first 3 pushed, 4th and 5th dropped; rep_fail=1, count=3. Then a different word → pushed, count=4.
- Read DATA while empty → rdata=0, underflow=1. Write CTRL=0 (enable=0), then push words → count unchanged.
- Full FIFO, rng_valid in the same cycle as a DATA pop → count stays 8, overflow stays 0. Access at BASE_ADDR+0xC → mem_ready never asserts.
